// File: rtl/multicycle_control.sv
// Multicycle control unit for the MIPS-style processor.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// drives the ALU op code, datapath enables and the req/ack memory handshake.
// Build option: define ILLEGAL_TRAP_EN to park the FSM in HALT on an illegal
// instruction; otherwise an illegal instruction pulses Illegal and acts as a NOP.
//
// state | meaning
// INIT  | post-reset idle cycle, all outputs low
// IF    | fetch request held until Mem_ack, then load IR and PC+4
// DEC   | decode IR; unconditional branch resolves here
// EXE   | ALU operation; conditional branches resolve on ALU_zero
// MEM   | data memory request for lw/sw, held until Mem_ack
// WB    | register file write (ALU result or load data)
// HALT  | trapped on illegal instruction, only reachable with ILLEGAL_TRAP_EN
module multicycle_control #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        ALU_zero,
  input  logic        Mem_ack,
  output logic [3:0]  ALU_op,
  output logic        ALU_Bin_sel,
  output logic        PC_LdEn,
  output logic        PC_sel,
  output logic        IR_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        Mem_req,
  output logic        Mem_WrEn,
  output logic        Illegal
);

  // Only an unbounded wait for Mem_ack is implemented.
  if (MEM_TIMEOUT != 0) begin : g_timeout_unsupported
    $error("multicycle_control: MEM_TIMEOUT must be 0");
  end

  typedef enum logic [2:0] {
    S_INIT, S_IF, S_DEC, S_EXE, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_IMM, C_LW, C_SW, C_BEQ, C_BNE, C_B, C_ILL
  } iclass_e;

  state_e      state_q, state_d;
  iclass_e     cls;
  logic [3:0]  exe_op;
  logic        exe_bsel;
  logic        branch_take;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        unused_instr;

  assign opcode       = Instr[31:26];
  assign func         = Instr[5:0];
  assign unused_instr = ^Instr[25:6];

  // Instruction class, ALU op and B-operand select decoded from the IR.
  always_comb begin
    cls      = C_ILL;
    exe_op   = 4'b0000;
    exe_bsel = 1'b0;
    case (opcode)
      6'b100000: begin
        // Upper func bits must be zero so only the ten ALU codes are legal.
        if (func[5:4] == 2'b00 &&
            func[3:0] inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                              4'b1000, 4'b1010, 4'b1001, 4'b1100, 4'b1101}) begin
          cls    = C_R;
          exe_op = func[3:0];
        end
      end
      6'b110000: begin cls = C_IMM; exe_op = 4'b0000; exe_bsel = 1'b1; end
      6'b110010: begin cls = C_IMM; exe_op = 4'b0010; exe_bsel = 1'b1; end
      6'b110011: begin cls = C_IMM; exe_op = 4'b0011; exe_bsel = 1'b1; end
      6'b001111: begin cls = C_LW;  exe_op = 4'b0000; exe_bsel = 1'b1; end
      6'b011111: begin cls = C_SW;  exe_op = 4'b0000; exe_bsel = 1'b1; end
      6'b010000: begin cls = C_BEQ; exe_op = 4'b0001; end
      6'b010001: begin cls = C_BNE; exe_op = 4'b0001; end
      6'b111111: begin cls = C_B; end
      default:   cls = C_ILL;
    endcase
  end

  assign branch_take = (cls == C_BEQ) ? ALU_zero : !ALU_zero;

  // State register; reset forces INIT, whose outputs are all zero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // Next state and combinational outputs.
  always_comb begin
    state_d       = state_q;
    ALU_op        = 4'b0000;
    ALU_Bin_sel   = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    IR_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    Mem_req       = 1'b0;
    Mem_WrEn      = 1'b0;
    Illegal       = 1'b0;
    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF: begin
        Mem_req = 1'b1;
        if (Mem_ack) begin
          IR_LdEn = 1'b1;
          PC_LdEn = 1'b1;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        case (cls)
          C_B: begin
            PC_LdEn = 1'b1;
            PC_sel  = 1'b1;
            state_d = S_IF;
          end
          C_ILL: begin
            Illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d = S_IF;
`endif
          end
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        ALU_op      = exe_op;
        ALU_Bin_sel = exe_bsel;
        case (cls)
          C_BEQ, C_BNE: begin
            PC_LdEn = branch_take;
            PC_sel  = branch_take;
            state_d = S_IF;
          end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        Mem_req  = 1'b1;
        Mem_WrEn = (cls == C_SW);
        if (Mem_ack) state_d = (cls == C_SW) ? S_IF : S_WB;
      end
      S_WB: begin
        RF_WrEn       = 1'b1;
        RF_WrData_sel = (cls == C_LW);
        state_d       = S_IF;
      end
      S_HALT: Illegal = 1'b1;
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

- Multicycle control unit for the MIPS-style processor.
- Drives the ALU `Op` code, datapath enables and memory requests. It is the producing end of the ALU operation interface.
- Fetches through a req/ack memory handshake, decodes the instruction register and steps each instruction through fetch, decode, execute, memory and writeback states.
- Consumes the ALU `Zero` flag to resolve conditional branches.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 0: reserved; 0 means wait for `Mem_ack` indefinitely. Only 0 is supported.

Ports:
- `Clk`  in  1  system clock, rising-edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Instr`  in  32  instruction register contents (opcode `[31:26]`, func `[5:0]`).
- `ALU_zero`  in  1  `Zero` output of the ALU.
- `Mem_ack`  in  1  memory completed the current request this cycle.
- `ALU_op`  out  4  ALU operation code.
- `ALU_Bin_sel`  out  1  0 selects register B as ALU B operand; 1 selects the sign-extended immediate.
- `PC_LdEn`  out  1  PC load enable.
- `PC_sel`  out  1  0 loads PC+4; 1 loads the branch target (PC+4 + imm<<2).
- `IR_LdEn`  out  1  instruction register load.
- `RF_WrEn`  out  1  register file write.
- `RF_WrData_sel`  out  1  0 writes ALU result; 1 writes memory data.
- `Mem_req`  out  1  memory request; held until `Mem_ack`.
- `Mem_WrEn`  out  1  request is a write (valid with `Mem_req`).
- `Illegal`  out  1  unsupported opcode detected.

## Operation
ALU codes:
- `0000` add, `0001` sub, `0010` and, `0011` or, `0100` not
- `1000` sra, `1010` srl, `1001` sll, `1100` rol, `1101` ror

Opcodes:
- `100000` R-type: `ALU_op` = func`[3:0]`. Legal only for the ten codes above; any other func is illegal.
- `110000` addi, `110010` andi, `110011` ori: `ALU_op` add/and/or respectively, with `ALU_Bin_sel`=1.
- `001111` lw and `011111` sw: address = rs + imm, computed with add.
- `010000` beq, `010001` bne: compare with sub.
- `111111` b: unconditional branch.
- Every other opcode is illegal.

States and transitions:
- INIT: all outputs 0; always goes to IF.
- IF: `Mem_req`=1, `Mem_WrEn`=0. While `Mem_ack`=0, stay in IF.
  - On `Mem_ack`=1: `IR_LdEn`=1, `PC_LdEn`=1, `PC_sel`=0, then go to DEC.
- DEC: decode `Instr`. b: `PC_LdEn`=1, `PC_sel`=1, then IF. R/I/lw/sw/branch: go to EXE. Illegal: see Configuration.
- EXE: drive `ALU_op` and `ALU_Bin_sel`; the datapath registers the ALU result.
  - Branch: if `ALU_zero` (beq) or `!ALU_zero` (bne), `PC_LdEn`=1, `PC_sel`=1. Then IF.
  - lw/sw: go to MEM. R/I-type: go to WB.
- MEM: `Mem_req`=1, `Mem_WrEn`=1 for sw. Stay in MEM until `Mem_ack`.
  - On ack: sw goes to IF; lw goes to WB.
- WB: `RF_WrEn`=1; `RF_WrData_sel`=1 for lw, otherwise 0. Then IF.
- HALT (only with the macro defined): `Illegal`=1, all other outputs 0. No exit except reset.

Output rules:
- Outputs are combinational from state plus `Instr`, `Mem_ack` and `ALU_zero`.
- Outside EXE, `ALU_op`=`0000` and `ALU_Bin_sel`=0.

## Timing
- Reset asserted: state goes to INIT immediately and all outputs are 0, including `Mem_req`. This holds whether or not a request was pending.
  - Memory must drop any in-flight request when `Reset` is low.
- Cycle counts with `Mem_ack` returned in the same cycle as the request:
  - b: 2 cycles. beq/bne: 3 cycles. R/I-type and sw: 4 cycles. lw: 5 cycles.
- Each cycle of `Mem_ack`=0 adds one cycle in IF or MEM. `Mem_req` must not deassert before the ack.
- `Mem_ack` is ignored outside IF and MEM.
- `ALU_zero` is sampled only in EXE of a branch, in the same cycle as `ALU_op`=`0001`.
- After reset release: 1 cycle in INIT, then `Mem_req` rises on the next cycle.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - An illegal opcode or func in DEC drives `Illegal`=1 for that cycle and transitions to HALT.
  - In HALT, `Illegal` stays 1 and nothing further is fetched until reset.
- `ILLEGAL_TRAP_EN` undefined:
  - An illegal instruction in DEC drives `Illegal`=1 for that single cycle only.
  - It is otherwise a NOP: no writes, PC already advanced, and the FSM returns to IF.

## Test plan
- Reset low mid-MEM of an sw (`Mem_req`=1, `Mem_WrEn`=1):
  - all outputs 0 asynchronously;
  - after release, 1 INIT cycle, then `Mem_req`=1 with `Mem_WrEn`=0.
- R-type func `1101` with immediate ack:
  - 4 cycles;
  - `ALU_op`=`1101` only in EXE;
  - `RF_WrEn`=1 for one cycle in WB with `RF_WrData_sel`=0.
- lw with `Mem_ack` delayed 3 cycles in IF and 2 in MEM:
  - 10 cycles total;
  - `Mem_req` continuous while waiting;
  - WB asserts `RF_WrData_sel`=1.
- beq with `ALU_zero`=1 → `PC_LdEn`=1, `PC_sel`=1 in EXE. bne with `ALU_zero`=1 → no PC load; next state IF.
- Opcode `000101`:
  - with `ILLEGAL_TRAP_EN` defined, `Illegal` stays 1 and `Mem_req` stays 0 for 20 cycles;
  - without it, `Illegal` pulses 1 cycle and the next fetch follows immediately.
- b: 2-cycle instruction; DEC asserts `PC_sel`=1 and `PC_LdEn`=1; no `RF_WrEn` and no `Mem_req` outside IF.
